// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port, word-wide RAM between the core's instruction-fetch
//   port (I, read-only) and load/store port (D). Requests are granted
//   round-robin. Each granted access runs IDLE -> ISSUE -> RESP -> IDLE. The
//   byte address is translated to a word address, and the RAM has a one-cycle
//   read latency. In RESP the granted port gets a one-cycle ready pulse,
//   together with read data and an out-of-range error flag.
//
// Ports
//   CLK, RESETN        clock (posedge) and asynchronous active-low reset
//   i_req/i_addr       fetch request level and byte address
//   i_ready/i_rdata    fetch completion pulse and fetched word
//   i_err              with i_ready: fetch address outside the RAM
//   d_req/d_we/d_wmask/d_addr/d_wdata
//                      load/store request, store flag, byte enables,
//                      byte address and store data
//   d_ready/d_rdata    load/store completion pulse and loaded word
//   d_err              with d_ready: access address outside the RAM
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata
//                      RAM interface (read data valid the cycle after mem_en)
//   busy               high whenever an access is in flight
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      CLK,
   input  logic                      RESETN,
   input  logic                      i_req,
   input  logic [31:0]               i_addr,
   output logic                      i_ready,
   output logic [DATA_WIDTH-1:0]     i_rdata,
   output logic                      i_err,
   input  logic                      d_req,
   input  logic                      d_we,
   input  logic [DATA_WIDTH/8-1:0]   d_wmask,
   input  logic [31:0]               d_addr,
   input  logic [DATA_WIDTH-1:0]     d_wdata,
   output logic                      d_ready,
   output logic [DATA_WIDTH-1:0]     d_rdata,
   output logic                      d_err,
   output logic                      mem_en,
   output logic [DATA_WIDTH/8-1:0]   mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   output logic                      busy
);

   localparam int MASK_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t                  state_r, state_s;
   logic                    grant_d_r, grant_d_s;   // 1 = current access belongs to D
   logic                    last_d_r, last_d_s;     // 1 = most recent grant went to D
   logic                    we_r, we_s;             // current access is a store
   logic                    err_r, err_s;           // current access is out of range
   logic                    mem_en_r, mem_en_s;
   logic [MASK_WIDTH-1:0]   mem_we_r, mem_we_s;
   logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_s;
   logic [DATA_WIDTH-1:0]   mem_wdata_r, mem_wdata_s;
   logic                    i_ready_r, i_ready_s;
   logic                    d_ready_r, d_ready_s;
   logic                    i_err_r, i_err_s;
   logic                    d_err_r, d_err_s;
   logic                    busy_r, busy_s;

   logic                    pick_d_s;
   logic [31:0]             req_addr_s;
   logic                    oor_s;
   logic                    unused_s;

   // Round-robin choice: a lone requester wins; on a contest the port that
   // did not win last time goes first (last_d_r resets to D, so I wins first).
   assign pick_d_s   = d_req & (~i_req | ~last_d_r);
   assign req_addr_s = pick_d_s ? d_addr : i_addr;
   assign oor_s      = |req_addr_s[31:ADDR_WIDTH+2];
   // Byte-offset bits are deliberately dropped; alignment is handled upstream.
   assign unused_s   = ^req_addr_s[1:0];

   // Next-state and next-output computation for the access sequencer.
   always_comb begin
      state_s     = state_r;
      grant_d_s   = grant_d_r;
      last_d_s    = last_d_r;
      we_s        = we_r;
      err_s       = err_r;
      mem_en_s    = 1'b0;
      mem_we_s    = {MASK_WIDTH{1'b0}};
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      i_ready_s   = 1'b0;
      d_ready_s   = 1'b0;
      i_err_s     = 1'b0;
      d_err_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (i_req || d_req) begin
               state_s    = ST_ISSUE;
               grant_d_s  = pick_d_s;
               last_d_s   = pick_d_s;
               we_s       = pick_d_s & d_we;
               err_s      = oor_s;
               mem_en_s   = ~oor_s;
               mem_addr_s = req_addr_s[ADDR_WIDTH+1:2];
               // I is read-only: only a D store in range may write.
               if (pick_d_s && d_we && !oor_s) begin
                  mem_we_s = d_wmask;
               end else begin
                  mem_we_s = {MASK_WIDTH{1'b0}};
               end
               if (pick_d_s) begin
                  mem_wdata_s = d_wdata;
               end else begin
                  mem_wdata_s = mem_wdata_r;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_s   = ST_RESP;
            i_ready_s = ~grant_d_r;
            d_ready_s = grant_d_r;
            i_err_s   = ~grant_d_r & err_r;
            d_err_s   = grant_d_r & err_r;
         end
         ST_RESP: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Access context and registered outputs.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         grant_d_r   <= 1'b0;
         last_d_r    <= 1'b1;
         we_r        <= 1'b0;
         err_r       <= 1'b0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= {MASK_WIDTH{1'b0}};
         mem_addr_r  <= {ADDR_WIDTH{1'b0}};
         mem_wdata_r <= {DATA_WIDTH{1'b0}};
         i_ready_r   <= 1'b0;
         d_ready_r   <= 1'b0;
         i_err_r     <= 1'b0;
         d_err_r     <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         grant_d_r   <= grant_d_s;
         last_d_r    <= last_d_s;
         we_r        <= we_s;
         err_r       <= err_s;
         mem_en_r    <= mem_en_s;
         mem_we_r    <= mem_we_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         i_ready_r   <= i_ready_s;
         d_ready_r   <= d_ready_s;
         i_err_r     <= i_err_s;
         d_err_r     <= d_err_s;
         busy_r      <= busy_s;
      end
   end

   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign i_ready   = i_ready_r;
   assign d_ready   = d_ready_r;
   assign i_err     = i_err_r;
   assign d_err     = d_err_r;
   assign busy      = busy_r;

   // Read data arrives from the RAM during RESP itself, so it is steered
   // straight through; it is forced to zero for stores, errors and idle ports.
   assign i_rdata = (i_ready_r && !err_r) ? mem_rdata : {DATA_WIDTH{1'b0}};
   assign d_rdata = (d_ready_r && !err_r && !we_r) ? mem_rdata : {DATA_WIDTH{1'b0}};

endmodule
